// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg: shared pipeline-register widths and control-bit ordering.
package ex_mem_reg_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF = 5;
  // MSB-first ordering of the control bits carried down the pipeline
  typedef struct packed {
    logic regWrite;
    logic memtoReg;
    logic branch;
    logic memRead;
    logic memWrite;
  } ctrl_t;
endpackage

// File: rtl/ex_mem_reg_branch_adder.sv
// branch_adder: branch target = PC+4 plus word-scaled offset, wrapping.
module branch_adder #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);
  assign sum = a + (b << 2);
endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with stall, flush and branch resolve.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W = REG_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall_in,
  input  logic              Flush_in,
  input  logic              Valid_in,
  input  logic [DATA_W-1:0] PCAddResult_in,
  input  logic [DATA_W-1:0] signExtend_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic              Zero_in,
  input  logic [DATA_W-1:0] ReadData2_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              RegDst_in,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              Branch_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  output logic [DATA_W-1:0] BranchTarget_out,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [DATA_W-1:0] WriteData_out,
  output logic [REG_W-1:0]  WriteReg_out,
  output logic              Zero_out,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic              Branch_out,
  output logic              MemRead_out,
  output logic              MemWrite_out,
  output logic              Valid_out,
  output logic              PCSrc_out
);
  typedef struct packed {
    logic [DATA_W-1:0] branchTarget;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] writeData;
    logic [REG_W-1:0]  writeReg;
    logic              zero;
    logic              valid;
    ctrl_t             ctrl;
  } stage_t;
  stage_t d, q;
  logic [DATA_W-1:0] branchTarget;
  logic [REG_W-1:0] writeReg;
  branch_adder #(.DATA_W(DATA_W)) targetAdder (
    .a(PCAddResult_in),
    .b(signExtend_in),
    .sum(branchTarget)
  );
  assign writeReg = RegDst_in ? rd_in : rt_in;
  // controls are squashed for bubbles; $0 never gets written; store beats load
  always_comb begin
    d.branchTarget = branchTarget;
    d.aluResult = ALUResult_in;
    d.writeData = ReadData2_in;
    d.writeReg = writeReg;
    d.zero = Zero_in;
    d.valid = Valid_in;
    d.ctrl.regWrite = Valid_in & RegWrite_in & (writeReg != '0);
    d.ctrl.memtoReg = Valid_in & MemtoReg_in;
    d.ctrl.branch = Valid_in & Branch_in;
    d.ctrl.memRead = Valid_in & MemRead_in & ~MemWrite_in;
    d.ctrl.memWrite = Valid_in & MemWrite_in;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) q <= '0;
    else if (Flush_in) q <= '0;
    else if (!Stall_in) q <= d;
  assign BranchTarget_out = q.branchTarget;
  assign ALUResult_out = q.aluResult;
  assign WriteData_out = q.writeData;
  assign WriteReg_out = q.writeReg;
  assign Zero_out = q.zero;
  assign RegWrite_out = q.ctrl.regWrite;
  assign MemtoReg_out = q.ctrl.memtoReg;
  assign Branch_out = q.ctrl.branch;
  assign MemRead_out = q.ctrl.memRead;
  assign MemWrite_out = q.ctrl.memWrite;
  assign Valid_out = q.valid;
  assign PCSrc_out = q.valid & q.ctrl.branch & q.zero;
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed checks of the EX/MEM register against hand-computed values.
module tb_ex_mem_reg;
  logic Clk = 0, Reset = 0, Stall_in = 0, Flush_in = 0, Valid_in = 0;
  logic [31:0] PCAddResult_in = 0, signExtend_in = 0, ALUResult_in = 0, ReadData2_in = 0;
  logic Zero_in = 0;
  logic [4:0] rt_in = 0, rd_in = 0;
  logic RegDst_in = 0, RegWrite_in = 0, MemtoReg_in = 0, Branch_in = 0, MemRead_in = 0, MemWrite_in = 0;
  logic [31:0] BranchTarget_out, ALUResult_out, WriteData_out;
  logic [4:0] WriteReg_out;
  logic Zero_out, RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out, Valid_out, PCSrc_out;
  int nCmp = 0, nErr = 0;

  ex_mem_reg dut (
    .Clk(Clk), .Reset(Reset), .Stall_in(Stall_in), .Flush_in(Flush_in), .Valid_in(Valid_in),
    .PCAddResult_in(PCAddResult_in), .signExtend_in(signExtend_in), .ALUResult_in(ALUResult_in),
    .Zero_in(Zero_in), .ReadData2_in(ReadData2_in), .rt_in(rt_in), .rd_in(rd_in),
    .RegDst_in(RegDst_in), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .Branch_in(Branch_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .BranchTarget_out(BranchTarget_out), .ALUResult_out(ALUResult_out),
    .WriteData_out(WriteData_out), .WriteReg_out(WriteReg_out), .Zero_out(Zero_out),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .Branch_out(Branch_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .Valid_out(Valid_out),
    .PCSrc_out(PCSrc_out)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] allOut();
    return {BranchTarget_out, ALUResult_out, WriteData_out, WriteReg_out, Zero_out,
            RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out, Valid_out, PCSrc_out};
  endfunction

  // {RegWrite, MemtoReg, Branch, MemRead, MemWrite, Valid, PCSrc}
  function automatic logic [127:0] flags();
    return {RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out, Valid_out, PCSrc_out};
  endfunction

  initial begin
    #1 Reset = 1;
    #1 chk("reset_async", allOut(), '0);
    tick();
    chk("reset_held", allOut(), '0);
    Reset = 0;

    PCAddResult_in = 32'h104; signExtend_in = 32'h3; RegDst_in = 1; rd_in = 8; rt_in = 5;
    RegWrite_in = 1; Valid_in = 1; ALUResult_in = 32'h11; ReadData2_in = 32'h22;
    MemtoReg_in = 1; MemRead_in = 1;
    tick();
    chk("load_target", BranchTarget_out, 32'h110);
    chk("load_wreg", WriteReg_out, 8);
    chk("load_data", {ALUResult_out, WriteData_out}, {32'h11, 32'h22});
    chk("load_flags", flags(), 7'b1101010);

    PCAddResult_in = 32'h4; signExtend_in = 32'hFFFF_FFFE; RegDst_in = 0;
    tick();
    chk("neg_target", BranchTarget_out, 32'hFFFF_FFFC);
    chk("rt_select", WriteReg_out, 5);
    PCAddResult_in = 32'hFFFF_FFFC; signExtend_in = 32'h2;
    MemWrite_in = 1;
    tick();
    chk("wrap_target", BranchTarget_out, 32'h4);
    chk("mem_conflict", {MemRead_out, MemWrite_out}, 2'b01);

    MemWrite_in = 0; ALUResult_in = 32'hDEAD_BEEF;
    tick();
    chk("pre_stall", ALUResult_out, 32'hDEAD_BEEF);
    Stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      ALUResult_in = 32'h1000 + i; rd_in = 5'(i + 1); Valid_in = i[0];
      tick();
      chk("stall_hold_alu", ALUResult_out, 32'hDEAD_BEEF);
      chk("stall_hold_valid", {Valid_out, WriteReg_out}, {1'b1, 5'd5});
    end
    Flush_in = 1; Valid_in = 1;
    tick();
    chk("stall_flush", allOut(), '0);
    Stall_in = 0; Flush_in = 0;

    Valid_in = 1; Branch_in = 1; Zero_in = 1; MemtoReg_in = 0; MemRead_in = 0; RegWrite_in = 0;
    tick();
    chk("branch_taken", flags(), 7'b0010011);
    Zero_in = 0; Branch_in = 0; Valid_in = 0;
    #1 chk("pcsrc_no_comb_path", PCSrc_out, 1'b1);
    Zero_in = 1; Branch_in = 1; RegWrite_in = 1; MemtoReg_in = 1; MemWrite_in = 1;
    tick();
    chk("bubble_ctrl", flags(), 7'b0);
    chk("bubble_zero_kept", Zero_out, 1'b1);

    Valid_in = 1; Branch_in = 0; MemtoReg_in = 0; MemWrite_in = 0;
    RegDst_in = 0; rt_in = 0; rd_in = 9; RegWrite_in = 1;
    tick();
    chk("zero_reg_guard", {RegWrite_out, WriteReg_out}, 6'b0);

    rt_in = 3; ALUResult_in = 32'h55AA;
    tick();
    chk("pre_reset", {RegWrite_out, WriteReg_out, ALUResult_out}, {1'b1, 5'd3, 32'h55AA});
    #2 Reset = 1; Stall_in = 1;
    #1 chk("async_reset", allOut(), '0);
    Reset = 0; Stall_in = 0; ALUResult_in = 32'h7777;
    tick();
    chk("post_reset_load", {ALUResult_out, Valid_out, RegWrite_out}, {32'h7777, 1'b1, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameter DATA_W, 32, datapath width.
REQ-002 Parameter REG_W, 5, register-specifier width.
REQ-003 Clk  in  1  sole clock, rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 Stall_in  in  1  hold all stored state this cycle.
REQ-006 Flush_in  in  1  load a bubble this cycle.
REQ-007 Valid_in  in  1  EX stage holds a real instruction.
REQ-008 PCAddResult_in  in  DATA_W  PC+4 of the EX instruction.
REQ-009 signExtend_in  in  DATA_W  sign-extended immediate.
REQ-010 ALUResult_in  in  DATA_W  ALU result.
REQ-011 Zero_in  in  1  ALU zero flag.
REQ-012 ReadData2_in  in  DATA_W  store data (rt value).
REQ-013 rt_in, rd_in  in  REG_W each  destination candidates.
REQ-014 RegDst_in, RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in  in  1 each  control bits.
REQ-015 BranchTarget_out, ALUResult_out, WriteData_out  out  DATA_W each  registered values.
REQ-016 WriteReg_out  out  REG_W  registered destination register.
REQ-017 Zero_out, RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out, Valid_out  out  1 each  registered flags.
REQ-018 PCSrc_out  out  1  branch-taken indication to the fetch stage.

Function
REQ-019 All state SHALL update only on the rising Clk edge (except Reset); latency from inputs to registered outputs SHALL be exactly 1 cycle.
REQ-020 Per-edge priority SHALL be Reset > Flush_in > Stall_in > normal load.
REQ-021 Normal load: BranchTarget_out SHALL equal PCAddResult_in + (signExtend_in << 2), truncated modulo 2^DATA_W.
REQ-022 Normal load: WriteReg_out SHALL equal rd_in when RegDst_in=1, else rt_in.
REQ-023 Normal load: ALUResult_out, Zero_out, WriteData_out SHALL take ALUResult_in, Zero_in, ReadData2_in.
REQ-024 Normal load: Valid_out SHALL take Valid_in; the five control outputs SHALL take their inputs ANDed with Valid_in.
REQ-025 RegWrite_out SHALL be 0 whenever the selected destination register is 0.
REQ-026 Stall_in=1 (Flush_in=0): every stored field SHALL hold its previous value.
REQ-027 Flush_in=1: all outputs SHALL load 0, including Valid_out, regardless of Stall_in.
REQ-028 PCSrc_out SHALL be combinational: Valid_out AND Branch_out AND Zero_out; it SHALL not depend on any input port.
REQ-029 MemRead_out and MemWrite_out SHALL never both be 1; if both inputs are 1, MemWrite_out SHALL win and MemRead_out SHALL load 0.

Reset
REQ-030 Reset=1 SHALL immediately, without waiting for Clk, drive every registered output to 0; PCSrc_out follows as 0.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override both; the first edge after deassertion SHALL perform normal priority evaluation.

Structure
REQ-032 DATA_W, REG_W defaults and control-bit ordering SHALL live in the shared project header used by all pipeline registers.
REQ-033 The target adder SHALL be one sub-module, branch_adder (DATA_W-wide add with <<2 on operand B); all else inline.

Verification
REQ-034 Load: PCAddResult_in=0x00000104, signExtend_in=0x00000003, RegDst_in=1, rd_in=8, RegWrite_in=1, Valid_in=1 -> after 1 edge BranchTarget_out=0x00000110, WriteReg_out=8, RegWrite_out=1.
REQ-035 Wrap/negative: PCAddResult_in=0x00000004, signExtend_in=0xFFFFFFFE -> BranchTarget_out=0xFFFFFFFC; PCAddResult_in=0xFFFFFFFC, signExtend_in=0x00000002 -> 0x00000004.
REQ-036 Stall then flush: load ALUResult_in=0xDEADBEEF, then Stall_in=1 for 3 edges with changing inputs -> output stays 0xDEADBEEF; then Stall_in=Flush_in=1 -> all outputs 0, Valid_out=0.
REQ-037 Branch: Valid_in=1, Branch_in=1, Zero_in=1 -> PCSrc_out=1 after edge; same with Valid_in=0 -> PCSrc_out=0 and all control outputs 0.
REQ-038 $0 guard: RegDst_in=0, rt_in=0, RegWrite_in=1 -> RegWrite_out=0, WriteReg_out=0.
REQ-039 Async reset: assert Reset between edges with nonzero outputs -> all outputs 0 before next edge; deassert -> next edge loads normally.
